// File: rtl/joy_db15_tx.sv
// ============================================================================
// Module   : joy_db15_tx
// Brief    : Adapter-side DB15 joystick shift chain (parallel-in / serial-out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module joy_db15_tx #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic [5:0]  bit_count,
    output logic        link_active
);

    localparam int         c_half    = WIDTH / 2;
    localparam int         c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [5:0] c_width   = 6'(WIDTH);
    localparam logic [5:0] c_last    = 6'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    // Host pins are asynchronous: two-flop synchronisers plus an edge-detect stage
    logic r_clk_meta;
    logic r_clk_s;
    logic r_clk_d;
    logic r_load_meta;
    logic r_load_s;

    logic [WIDTH-1:0]   r_sr;
    logic [5:0]         r_bit_count;
    logic               r_frame_done;
    logic [c_cnt_w-1:0] r_timer;

    logic               w_clk_rise;
    logic               w_loading;
    logic               w_shift;
    logic               w_activity;
    logic [WIDTH-1:0]   w_load_val;

    assign w_clk_rise = r_clk_s & ~r_clk_d;
    assign w_loading  = ~r_load_s;
    assign w_shift    = r_load_s & w_clk_rise;
    assign w_activity = w_loading | w_clk_rise;

    // Player 2 MSB leaves first; buttons are active high, the wire is active low
    assign w_load_val = ~{joystick2[c_half-1:0], joystick1[c_half-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_s     <= 1'b1;
            r_clk_d     <= 1'b1;
            r_load_meta <= 1'b1;
            r_load_s    <= 1'b1;
        end else begin
            r_clk_meta  <= JOY_CLK;
            r_clk_s     <= r_clk_meta;
            r_clk_d     <= r_clk_s;
            r_load_meta <= JOY_LOAD;
            r_load_s    <= r_load_meta;
        end
    end

    // Load wins over a coincident shift edge; serial-in is pulled high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr         <= '1;
            r_bit_count  <= 6'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_loading) begin
                r_sr        <= w_load_val;
                r_bit_count <= 6'd0;
            end else if (w_shift) begin
                r_sr <= {r_sr[WIDTH-2:0], 1'b1};
                if (r_bit_count < c_width) begin
                    r_bit_count <= r_bit_count + 6'd1;
                end
                if (r_bit_count == c_last) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    // Idle timer saturates at TIMEOUT; any host activity restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= c_timeout;
        end else if (w_activity) begin
            r_timer <= '0;
        end else if (r_timer != c_timeout) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign JOY_DATA    = r_sr[WIDTH-1];
    assign frame_done  = r_frame_done;
    assign bit_count   = r_bit_count;
    assign link_active = (r_timer < c_timeout);

endmodule

`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
// ============================================================================
// Module   : tb_joy_db15_tx
// Brief    : Directed self-checking bench for joy_db15_tx (WIDTH=32, TIMEOUT=16)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_joy_db15_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic        frame_done;
    logic [5:0]  bit_count;
    logic        link_active;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;

    always #12.5 clk = ~clk;

    joy_db15_tx #(
        .WIDTH   (32),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .JOY_CLK     (JOY_CLK),
        .JOY_LOAD    (JOY_LOAD),
        .JOY_DATA    (JOY_DATA),
        .frame_done  (frame_done),
        .bit_count   (bit_count),
        .link_active (link_active)
    );

    // Advance n clk edges, sampling 1 ns after each edge and logging frame_done pulses
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        JOY_CLK   = 1'b0;
        JOY_LOAD  = 1'b1;
        joystick1 = 16'h0000;
        joystick2 = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            JOY_CLK  = ~JOY_CLK;
            JOY_LOAD = (i % 3 == 0) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if (JOY_DATA !== 1'b1) begin
                n_err++; $display("FAIL reset_data: got %b want 1", JOY_DATA);
            end
            n_cmp++;
            if (bit_count !== 6'd0) begin
                n_err++; $display("FAIL reset_bit_count: got %0d want 0", bit_count);
            end
            n_cmp++;
            if (link_active !== 1'b0) begin
                n_err++; $display("FAIL reset_link_active: got %b want 0", link_active);
            end
            n_cmp++;
            if (frame_done !== 1'b0) begin
                n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
            end
        end
        JOY_CLK  = 1'b0;
        JOY_LOAD = 1'b1;
        tick();
        reset_n = 1'b1;
        tick(5);
        n_cmp++;
        if (link_active !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset_link: got %b want 0", link_active);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] exp_bits;
        int          rise_cyc;
        exp_bits  = 32'h7FFF_FFFE;
        rise_cyc  = 0;
        joystick1 = 16'h0001;
        joystick2 = 16'h8000;
        JOY_LOAD  = 1'b0;
        tick(10);
        JOY_LOAD = 1'b1;
        tick(4);
        fd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (JOY_DATA !== exp_bits[31-i]) begin
                n_err++; $display("FAIL frame_bit%0d: got %b want %b", i, JOY_DATA, exp_bits[31-i]);
            end
            JOY_CLK = 1'b1;
            if (i == 31) rise_cyc = cyc;
            tick(4);
            JOY_CLK = 1'b0;
            tick(4);
            if (i == 15) begin
                n_cmp++;
                if (bit_count !== 6'd16) begin
                    n_err++; $display("FAIL frame_mid_count: got %0d want 16", bit_count);
                end
            end
        end
        n_cmp++;
        if (fd_cnt != 1) begin
            n_err++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt);
        end
        n_cmp++;
        if ((fd_cyc - rise_cyc) < 3 || (fd_cyc - rise_cyc) > 4) begin
            n_err++; $display("FAIL frame_done_delay: got %0d want 3..4", fd_cyc - rise_cyc);
        end
        n_cmp++;
        if (bit_count !== 6'd32) begin
            n_err++; $display("FAIL frame_end_count: got %0d want 32", bit_count);
        end
    endtask

    task automatic test_overclock();
        fd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (JOY_DATA !== 1'b1) begin
                n_err++; $display("FAIL overclock_pre%0d: got %b want 1", i, JOY_DATA);
            end
            JOY_CLK = 1'b1;
            tick(4);
            n_cmp++;
            if (JOY_DATA !== 1'b1) begin
                n_err++; $display("FAIL overclock_post%0d: got %b want 1", i, JOY_DATA);
            end
            JOY_CLK = 1'b0;
            tick(4);
        end
        n_cmp++;
        if (bit_count !== 6'd32) begin
            n_err++; $display("FAIL overclock_count: got %0d want 32", bit_count);
        end
        n_cmp++;
        if (fd_cnt != 0) begin
            n_err++; $display("FAIL overclock_frame_done: got %0d want 0", fd_cnt);
        end
    endtask

    task automatic test_load_priority();
        logic [31:0] exp_bits;
        exp_bits  = 32'hFFFF_FF00;
        joystick1 = 16'h00FF;
        joystick2 = 16'h0000;
        tick();
        JOY_LOAD = 1'b0;
        JOY_CLK  = 1'b1;
        tick(3);
        n_cmp++;
        if (bit_count !== 6'd0) begin
            n_err++; $display("FAIL prio_count: got %0d want 0", bit_count);
        end
        n_cmp++;
        if (JOY_DATA !== 1'b1) begin
            n_err++; $display("FAIL prio_data: got %b want 1", JOY_DATA);
        end
        tick(3);
        JOY_CLK = 1'b0;
        tick(4);
        JOY_LOAD = 1'b1;
        tick(4);
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (JOY_DATA !== exp_bits[31-i]) begin
                n_err++; $display("FAIL prio_bit%0d: got %b want %b", i, JOY_DATA, exp_bits[31-i]);
            end
            JOY_CLK = 1'b1;
            tick(4);
            JOY_CLK = 1'b0;
            tick(4);
        end
    endtask

    task automatic test_latency();
        joystick1 = 16'h0000;
        joystick2 = 16'h4000;
        JOY_LOAD  = 1'b0;
        tick(4);
        JOY_LOAD = 1'b1;
        tick(4);
        n_cmp++;
        if (JOY_DATA !== 1'b1) begin
            n_err++; $display("FAIL latency_start: got %b want 1", JOY_DATA);
        end
        JOY_CLK = 1'b1;
        tick(2);
        n_cmp++;
        if (JOY_DATA !== 1'b1 || bit_count !== 6'd0) begin
            n_err++; $display("FAIL latency_t2: got data=%b count=%0d want data=1 count=0", JOY_DATA, bit_count);
        end
        tick();
        n_cmp++;
        if (JOY_DATA !== 1'b0 || bit_count !== 6'd1) begin
            n_err++; $display("FAIL latency_t3: got data=%b count=%0d want data=0 count=1", JOY_DATA, bit_count);
        end
        JOY_CLK = 1'b0;
        tick(4);
    endtask

    task automatic test_midframe_reset();
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (JOY_DATA !== 1'b1 || bit_count !== 6'd0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL midreset_async: got data=%b count=%0d fd=%b want 1/0/0", JOY_DATA, bit_count, frame_done);
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
        JOY_CLK = 1'b1;
        tick(4);
        n_cmp++;
        if (JOY_DATA !== 1'b1 || bit_count !== 6'd1) begin
            n_err++; $display("FAIL midreset_noload_shift: got data=%b count=%0d want data=1 count=1", JOY_DATA, bit_count);
        end
        JOY_CLK = 1'b0;
        tick(4);
    endtask

    task automatic test_timeout();
        tick(25);
        n_cmp++;
        if (link_active !== 1'b0) begin
            n_err++; $display("FAIL timeout_idle: got %b want 0", link_active);
        end
        JOY_LOAD = 1'b0;
        tick();
        JOY_LOAD = 1'b1;
        tick();
        n_cmp++;
        if (link_active !== 1'b0) begin
            n_err++; $display("FAIL timeout_t2: got %b want 0", link_active);
        end
        tick();
        n_cmp++;
        if (link_active !== 1'b1) begin
            n_err++; $display("FAIL timeout_t3: got %b want 1", link_active);
        end
        tick(15);
        n_cmp++;
        if (link_active !== 1'b1) begin
            n_err++; $display("FAIL timeout_t18: got %b want 1", link_active);
        end
        tick();
        n_cmp++;
        if (link_active !== 1'b0) begin
            n_err++; $display("FAIL timeout_t19: got %b want 0", link_active);
        end
        JOY_CLK = 1'b1;
        tick(2);
        n_cmp++;
        if (link_active !== 1'b0) begin
            n_err++; $display("FAIL timeout_clk_t2: got %b want 0", link_active);
        end
        tick();
        n_cmp++;
        if (link_active !== 1'b1) begin
            n_err++; $display("FAIL timeout_clk_t3: got %b want 1", link_active);
        end
        JOY_CLK = 1'b0;
        tick(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_overclock();
        test_load_priority();
        test_latency();
        test_midframe_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Target/adapter-side model of the DB15 serial joystick link: the other end of the link that the host's DB15 reader drives.
- Emulates the adapter's parallel-in/serial-out shift chain. Two 16-bit player words are loaded while JOY_LOAD is low and shifted out MSB-first on JOY_DATA on each rising JOY_CLK edge.
- Used as the bench/loopback partner for the host-side DB15 reader, and as target logic on a user-port test board.
- Host pins are asynchronous to clk and are synchronised internally.

Parameters:
- WIDTH, 32, number of bits in one frame; must be even, 2..32. Each player contributes WIDTH/2 low bits of its word.
- TIMEOUT, 65536, clk cycles without host activity before link_active deasserts.

Ports:
- clk  in  1  core clock, 40-50 MHz
- reset_n  in  1  asynchronous active-low reset
- joystick1  in  16  player 1 buttons, active high, order FEDCBAUDLR + extras
- joystick2  in  16  player 2 buttons, active high
- JOY_CLK  in  1  host shift clock, asynchronous
- JOY_LOAD  in  1  host parallel load, active low, asynchronous
- JOY_DATA  out  1  serial data to host, active low (0 = pressed)
- frame_done  out  1  one-cycle pulse when the WIDTH-th bit has been shifted
- bit_count  out  6  bits shifted since last load, saturates at WIDTH
- link_active  out  1  host activity seen within the last TIMEOUT cycles

Behaviour:
- Reset (async, reset_n=0):
  - sync FFs = 1
  - sr = all 1s, so JOY_DATA = 1
  - bit_count = 0, frame_done = 0
  - timeout counter = TIMEOUT, so link_active = 0
- Synchronisers: JOY_CLK and JOY_LOAD each pass through 2 FFs (clk_s, load_s). clk_d is clk_s delayed 1 cycle. clk_rise = clk_s & ~clk_d.
- Latency: a pin transition affects sr/JOY_DATA on the 3rd clk rising edge after the transition (2 sync edges + 1 register edge). JOY_DATA is driven directly from sr[WIDTH-1], with no extra register.
- Load value: L = ~{joystick2[WIDTH/2-1:0], joystick1[WIDTH/2-1:0]}.
  - Player 2 MSB exits first.
  - joystick1 bit0 exits last.
- While load_s = 0:
  - every cycle, sr <= L and bit_count <= 0 (transparent load; the last cycle's sample is held).
  - clk_rise is ignored; load has priority over a simultaneous clock edge.
- When load_s = 1 and clk_rise:
  - sr <= {sr[WIDTH-2:0], 1'b1}
  - if bit_count < WIDTH, bit_count increments.
- frame_done = 1 for exactly the cycle after bit_count goes from WIDTH-1 to WIDTH.
- Over-clocking past WIDTH:
  - JOY_DATA = 1 (serial-in is pulled high)
  - bit_count holds at WIDTH
  - no further frame_done.
- Shifting without a prior load shifts the reset/previous contents. No error is flagged.
- Activity = (load_s == 0) | clk_rise.
  - On activity, the timeout counter <= 0.
  - Otherwise it increments, saturating at TIMEOUT.
  - link_active = (counter < TIMEOUT).
- Reset asserted mid-frame: immediate return to reset values. The next frame requires a fresh load.
- joystick inputs are assumed synchronous to clk. No filtering.

Test Plan:
- Reset: reset_n=0 with JOY_CLK/JOY_LOAD toggling -> JOY_DATA=1, bit_count=0, link_active=0, frame_done=0 throughout.
- Basic frame, WIDTH=32:
  - Stimulus: joystick1=16'h0001, joystick2=16'h8000, JOY_LOAD low 10 cycles then high, 32 JOY_CLK pulses (period 8 clk).
  - Required: sampled JOY_DATA sequence (before each rise) = 0, then 30 ones, then 0.
  - Required: frame_done pulses once, 3-4 clk after the 32nd rise; bit_count=32.
- Over-clock: 5 extra JOY_CLK pulses after the frame -> JOY_DATA=1 on all, bit_count stays 32, no second frame_done.
- Load priority: JOY_LOAD falls on the same clk as a JOY_CLK rise, with joystick1=16'h00FF -> sr reloaded, bit_count=0, no shift. After release, the first 24 bits read 1 and the last 8 read 0.
- Latency: single JOY_CLK rise at clk edge t -> JOY_DATA changes at edge t+3, not t+2.
- Timeout (TIMEOUT=16 override):
  - One load pulse -> link_active=1 from the cycle after load_s low, and stays 1 for 16 idle cycles, then drops to 0.
  - A JOY_CLK rise re-asserts it.
